// File: rtl/axi_rd_page_responder.sv
// AXI4 read responder with page-aware hit/miss latency and address-derived data.
// Optional AXI_RD_RESPONDER_STATS_EN adds saturating hit/miss/beat counters.
module axi_rd_page_responder #(
    parameter int DATA_WIDTH               = 256,
    parameter int ADDR_WIDTH               = 16,
    parameter int ID_WIDTH                 = 8,
    parameter int FIFO_QUEUE_WIDTH         = 5,
    parameter int PAGE_OFFSET_WIDTH        = 11,
    parameter int SHORT_DELAY_CYCLES_WIDTH = 7,
    parameter int SHORT_DELAY_CYCLES       = 80,
    parameter int LONG_DELAY_CYCLES_WIDTH  = 7,
    parameter int LONG_DELAY_CYCLES        = 100
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_WIDTH-1:0]   s_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [ID_WIDTH-1:0]   s_axi_rid,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready
`ifdef AXI_RD_RESPONDER_STATS_EN
    ,
    output logic [31:0]           stat_hits,
    output logic [31:0]           stat_misses,
    output logic [31:0]           stat_beats
`endif
);

    localparam int DEPTH   = 1 << FIFO_QUEUE_WIDTH;
    localparam int ENTRY_W = ID_WIDTH + ADDR_WIDTH + 8;
    localparam int PAGE_W  = ADDR_WIDTH - PAGE_OFFSET_WIDTH;
    localparam int REP     = DATA_WIDTH / ADDR_WIDTH;
    localparam int DLY_W   = (SHORT_DELAY_CYCLES_WIDTH > LONG_DELAY_CYCLES_WIDTH)
                           ? SHORT_DELAY_CYCLES_WIDTH : LONG_DELAY_CYCLES_WIDTH;

    localparam logic [DLY_W-1:0] SHORT_LOAD = DLY_W'(SHORT_DELAY_CYCLES - 1);
    localparam logic [DLY_W-1:0] LONG_LOAD  = DLY_W'(LONG_DELAY_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] BEAT_INC = ADDR_WIDTH'(DATA_WIDTH / 8);
    localparam logic [FIFO_QUEUE_WIDTH:0] FULL_CNT = (FIFO_QUEUE_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_BURST
    } state_t;

    state_t state, state_nxt;

    logic [ENTRY_W-1:0]          mem [DEPTH];
    logic [FIFO_QUEUE_WIDTH-1:0] wr_ptr;
    logic [FIFO_QUEUE_WIDTH-1:0] rd_ptr;
    logic [FIFO_QUEUE_WIDTH:0]   count;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic                        push;
    logic                        pop;

    logic [ID_WIDTH-1:0]   head_id;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [7:0]            head_len;
    logic [PAGE_W-1:0]     head_page;
    logic                  hit;

    logic [PAGE_W-1:0]     open_page;
    logic                  page_valid;
    logic [DLY_W-1:0]      dly_cnt;
    logic [7:0]            beat_cnt;
    logic [ID_WIDTH-1:0]   b_id;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [7:0]            b_len;
    logic                  last_beat;
    logic                  r_hs;

    assign fifo_full     = (count == FULL_CNT);
    assign fifo_empty    = (count == '0);
    assign s_axi_arready = !fifo_full;
    assign push          = s_axi_arvalid && !fifo_full;

    assign {head_id, head_addr, head_len} = mem[rd_ptr];
    assign head_page = head_addr[ADDR_WIDTH-1:PAGE_OFFSET_WIDTH];
    assign hit       = page_valid && (head_page == open_page);

    assign last_beat   = (beat_cnt == b_len);
    assign r_hs        = s_axi_rvalid && s_axi_rready;
    assign s_axi_rresp = 2'b00;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {s_axi_arid, s_axi_araddr, s_axi_arlen};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + FIFO_QUEUE_WIDTH'(1);
            if (pop)  rd_ptr <= rd_ptr + FIFO_QUEUE_WIDTH'(1);
            if (push && !pop) begin
                count <= count + (FIFO_QUEUE_WIDTH + 1)'(1);
            end else if (pop && !push) begin
                count <= count - (FIFO_QUEUE_WIDTH + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        pop          = 1'b0;
        s_axi_rvalid = 1'b0;
        s_axi_rlast  = 1'b0;
        s_axi_rid    = '0;
        s_axi_rdata  = '0;
        unique case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (dly_cnt == '0) state_nxt = ST_BURST;
            end
            ST_BURST: begin
                s_axi_rvalid = 1'b1;
                s_axi_rlast  = last_beat;
                s_axi_rid    = b_id;
                s_axi_rdata  = {REP{b_addr}};
                if (s_axi_rready && last_beat) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Page state follows the burst start address only; crossings are free.
    always_ff @(posedge clk) begin
        if (rst) begin
            dly_cnt    <= '0;
            beat_cnt   <= '0;
            page_valid <= 1'b0;
            open_page  <= '0;
            b_id       <= '0;
            b_addr     <= '0;
            b_len      <= '0;
        end else begin
            if (pop) begin
                dly_cnt    <= hit ? SHORT_LOAD : LONG_LOAD;
                open_page  <= head_page;
                page_valid <= 1'b1;
                b_id       <= head_id;
                b_addr     <= head_addr;
                b_len      <= head_len;
                beat_cnt   <= '0;
            end else if (state == ST_WAIT && dly_cnt != '0) begin
                dly_cnt <= dly_cnt - DLY_W'(1);
            end
            if (r_hs) begin
                b_addr   <= b_addr + BEAT_INC;
                beat_cnt <= beat_cnt + 8'd1;
            end
        end
    end

`ifdef AXI_RD_RESPONDER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_hits   <= '0;
            stat_misses <= '0;
            stat_beats  <= '0;
        end else begin
            if (pop && hit && stat_hits != '1) begin
                stat_hits <= stat_hits + 32'd1;
            end
            if (pop && !hit && stat_misses != '1) begin
                stat_misses <= stat_misses + 32'd1;
            end
            if (r_hs && stat_beats != '1) begin
                stat_beats <= stat_beats + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_axi_rd_page_responder.sv
// Directed bench for axi_rd_page_responder: latency, data, backpressure,
// FIFO full and reset-abort sequences with hand-computed expectations.
module tb_axi_rd_page_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  arid;
    logic [15:0] araddr;
    logic [7:0]  arlen;
    logic        arvalid;
    logic        arready;
    logic [7:0]  rid;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    axi_rd_page_responder #(
        .DATA_WIDTH         (64),
        .ADDR_WIDTH         (16),
        .ID_WIDTH           (8),
        .SHORT_DELAY_CYCLES (4),
        .LONG_DELAY_CYCLES  (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axi_arid    (arid),
        .s_axi_araddr  (araddr),
        .s_axi_arlen   (arlen),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rid     (rid),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rlast   (rlast),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready)
    );

    typedef struct {
        logic [7:0]  id;
        logic [15:0] addr;
        logic [7:0]  len;
        int          lat;
    } vec_t;

    vec_t vecs[7];

    function automatic logic [63:0] rep(input logic [15:0] a);
        return {4{a}};
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic ar_send(input logic [7:0] id, input logic [15:0] addr,
                           input logic [7:0] len);
        int n;
        n = 0;
        @(negedge clk);
        arid    = id;
        araddr  = addr;
        arlen   = len;
        arvalid = 1'b1;
        while (!arready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (arready) begin
            @(posedge clk);
            #1;
        end else begin
            chk("ar_timeout", 64'(arready), 64'd1);
        end
        arvalid = 1'b0;
    endtask

    task automatic wait_first(output int n);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!rvalid && n < 200);
    endtask

    task automatic check_burst(input logic [7:0] id, input logic [15:0] addr,
                               input logic [7:0] len);
        logic [15:0] a;
        a = addr;
        for (int b = 0; b <= int'(len); b++) begin
            int n;
            n = 0;
            while (!rvalid && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("beat_valid", 64'(rvalid), 64'd1);
            chk("rdata", rdata, rep(a));
            chk("rid", 64'(rid), 64'(id));
            chk("rlast", 64'(rlast), 64'(b == int'(len)));
            chk("rresp", 64'(rresp), 64'd0);
            @(posedge clk);
            @(negedge clk);
            a = a + 16'd8;
        end
        chk("bubble", 64'(rvalid), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int acc;
        int idx;
        int seen;
        logic [63:0] hold_data;

        vecs[0] = '{8'd5,  16'h0100, 8'd0, 9};
        vecs[1] = '{8'd6,  16'h0140, 8'd3, 5};
        vecs[2] = '{8'd7,  16'h0800, 8'd0, 9};
        vecs[3] = '{8'd8,  16'h0000, 8'd0, 9};
        vecs[4] = '{8'd9,  16'h0010, 8'd1, 5};
        vecs[5] = '{8'd10, 16'h07F8, 8'd1, 5};
        vecs[6] = '{8'd11, 16'h0808, 8'd0, 9};

        rst     = 1'b1;
        arvalid = 1'b0;
        arid    = '0;
        araddr  = '0;
        arlen   = '0;
        rready  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        chk("rst_arready", 64'(arready), 64'd1);
        chk("rst_rdata", rdata, 64'd0);
        chk("rst_rid", 64'(rid), 64'd0);
        chk("rst_rlast", 64'(rlast), 64'd0);
        chk("rst_rresp", 64'(rresp), 64'd0);
        rst = 1'b0;

        // Table: hit/miss latency and burst contents.
        rready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            ar_send(vecs[i].id, vecs[i].addr, vecs[i].len);
            wait_first(n);
            chk($sformatf("latency_v%0d", i), 64'(n), 64'(vecs[i].lat));
            check_burst(vecs[i].id, vecs[i].addr, vecs[i].len);
        end

        // Backpressure with address wrap.
        rready = 1'b0;
        ar_send(8'h22, 16'hFFF8, 8'd1);
        wait_first(n);
        chk("latency_wrap", 64'(n), 64'd9);
        chk("wrap_b0_data", rdata, rep(16'hFFF8));
        chk("wrap_b0_last", 64'(rlast), 64'd0);
        hold_data = rdata;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            chk("stall0_valid", 64'(rvalid), 64'd1);
            chk("stall0_data", rdata, hold_data);
            chk("stall0_id", 64'(rid), 64'h22);
            chk("stall0_last", 64'(rlast), 64'd0);
        end
        rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rready = 1'b0;
        chk("wrap_b1_valid", 64'(rvalid), 64'd1);
        chk("wrap_b1_data", rdata, rep(16'h0000));
        chk("wrap_b1_last", 64'(rlast), 64'd1);
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            chk("stall1_data", rdata, rep(16'h0000));
            chk("stall1_id", 64'(rid), 64'h22);
            chk("stall1_last", 64'(rlast), 64'd1);
        end
        rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("wrap_done", 64'(rvalid), 64'd0);

        // FIFO full: a stalled burst keeps the first queued pop pending.
        rready = 1'b0;
        ar_send(8'h40, 16'h0000, 8'd0);
        wait_first(n);
        chk("latency_blocker", 64'(n), 64'd9);
        acc     = 0;
        idx     = 0;
        arid    = 8'd0;
        araddr  = 16'd0;
        arlen   = 8'd0;
        arvalid = 1'b1;
        for (int c = 0; c < 40 && acc < 32; c++) begin
            if (arready) begin
                @(posedge clk);
                acc++;
                idx++;
                #1;
                arid   = 8'(idx);
                araddr = 16'(idx * 8);
            end else begin
                @(posedge clk);
            end
            @(negedge clk);
        end
        chk("full_accepts", 64'(acc), 64'd32);
        for (int s = 0; s < 3; s++) begin
            chk("full_arready", 64'(arready), 64'd0);
            @(negedge clk);
        end
        rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("full_no_bypass", 64'(arready), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("full_reassert", 64'(arready), 64'd1);
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        for (int i = 0; i < 33; i++) begin
            check_burst(8'(i), 16'(i * 8), 8'd0);
        end

        // Reset in the middle of a burst with three requests queued.
        ar_send(8'h50, 16'h0200, 8'd7);
        ar_send(8'h51, 16'h0300, 8'd0);
        ar_send(8'h52, 16'h0400, 8'd0);
        ar_send(8'h53, 16'h0500, 8'd0);
        n = 0;
        @(negedge clk);
        while (!rvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("mid_b0_data", rdata, rep(16'h0200));
        @(posedge clk);
        @(negedge clk);
        chk("mid_b1_data", rdata, rep(16'h0208));
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_rvalid", 64'(rvalid), 64'd0);
        chk("mid_rst_arready", 64'(arready), 64'd1);
        rst  = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (rvalid) seen++;
        end
        chk("mid_no_beats", 64'(seen), 64'd0);
        ar_send(8'h60, 16'h0200, 8'd0);
        wait_first(n);
        chk("latency_after_rst", 64'(n), 64'd9);
        check_burst(8'h60, 16'h0200, 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axi_rd_page_responder.md
Name: axi_rd_page_responder

Overview:
- Synthesizable AXI4 read-channel responder (AR in, R out) that models LPDDR5 page-aware latency.
- It is the slave end of the read interface driven by the prefetcher's master port, and of the GPU trace-player ports in standalone benches.
- Accepted requests are buffered in an in-order FIFO and served one at a time.
- Each request waits a short delay on an open-page hit or a long delay on a page miss, then returns a deterministic, address-derived data burst.

Parameters:
- DATA_WIDTH, 256, R data width in bits (power of 2, >= ADDR_WIDTH).
- ADDR_WIDTH, 16, byte address width.
- ID_WIDTH, 8, transaction ID width.
- FIFO_QUEUE_WIDTH, 5, log2 of the request FIFO depth (32 entries).
- PAGE_OFFSET_WIDTH, 11, page size = 2^11 bytes.
- SHORT_DELAY_CYCLES_WIDTH, 7, width of the short-delay constant.
- SHORT_DELAY_CYCLES, 80, page-hit latency; must be >= 1.
- LONG_DELAY_CYCLES_WIDTH, 7, width of the long-delay constant.
- LONG_DELAY_CYCLES, 100, page-miss latency; must be >= 1.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- s_axi_arid  in  ID_WIDTH  request ID.
- s_axi_araddr  in  ADDR_WIDTH  burst start byte address.
- s_axi_arlen  in  8  beats minus 1.
- s_axi_arvalid  in  1  request valid.
- s_axi_arready  out  1  request accept.
- s_axi_rid  out  ID_WIDTH  ID of the current burst.
- s_axi_rdata  out  DATA_WIDTH  beat data.
- s_axi_rresp  out  2  always 2'b00.
- s_axi_rlast  out  1  final beat of the burst.
- s_axi_rvalid  out  1  beat valid.
- s_axi_rready  in  1  beat accept.

Behaviour:
- Reset (clk edge with rst=1):
  - FIFO emptied; state=IDLE; delay counter=0; beat counter=0.
  - page_valid=0; rvalid=0; rlast=0; rid=0; rdata=0; rresp=0.
  - arready reads 1 in the first cycle after reset.
  - Reset mid-burst or mid-wait drops all queued and in-flight requests; no partial beats are emitted afterwards.
- AR channel:
  - arready = !fifo_full, combinational from FIFO state only.
  - Push {id, addr, len} on arvalid & arready.
  - Full FIFO: arready=0 even if a pop happens in the same cycle (no full-bypass).
  - Push and pop in the same cycle are legal when not full; the count stays unchanged.
- FSM IDLE:
  - If the FIFO is non-empty, pop the head and go to WAIT.
  - On pop, compute page = addr >> PAGE_OFFSET_WIDTH.
  - Hit = page_valid & (page == open_page).
  - Load delay counter with (hit ? SHORT_DELAY_CYCLES : LONG_DELAY_CYCLES) - 1.
  - Set open_page = page and page_valid = 1.
  - Latch id, addr and len as burst state; beat counter = 0.
- FSM WAIT:
  - Decrement the counter each cycle.
  - At counter==0, go to BURST.
  - Timing: for an idle responder with an empty FIFO, first rvalid is high exactly D+1 cycles after the AR handshake edge (D = selected delay).
- FSM BURST:
  - rvalid=1 and rid = latched id.
  - rdata = current beat address, zero-extended to ADDR_WIDTH and replicated DATA_WIDTH/ADDR_WIDTH times.
  - rlast = (beat counter == len).
  - Outputs hold stable while rvalid & !rready.
  - On handshake: beat address += DATA_WIDTH/8, modulo 2^ADDR_WIDTH (wraps); beat counter += 1.
  - On the handshake with rlast: go to IDLE, rvalid=0. Next pop is one cycle later, so there is at least one bubble cycle between bursts.
- Page checking uses the start address only. A burst crossing a page pays no extra latency, and open_page is not updated to the crossed page.
- Responses are strictly in acceptance order; IDs are not used for reordering.
- len=0 gives a single beat with rlast=1.
- len=255 gives 256 beats; the beat counter is 8 bits.
- Write channels are not implemented.

Optional Feature:
- Macro: AXI_RD_RESPONDER_STATS_EN.
- When defined, adds output ports stat_hits (32), stat_misses (32) and stat_beats (32):
  - stat_hits and stat_misses increment on each pop according to the hit/miss decision.
  - stat_beats increments on each R handshake.
  - All three saturate at 2^32-1 and are cleared by rst.
- When undefined, these ports and counters do not exist; the remaining behaviour is identical.

Test Plan:
- Bench settings: SHORT_DELAY_CYCLES=4, LONG_DELAY_CYCLES=8, DATA_WIDTH=64, ADDR_WIDTH=16.
- Cold miss: rst, then AR addr=16'h0100, len=0, id=5.
  - rvalid high 9 cycles after the handshake edge.
  - rdata=64'h0100_0100_0100_0100, rid=5, rlast=1, rresp=0.
- Page hit: after the above, AR addr=16'h0140, len=3.
  - Page 0 again, so first beat 5 cycles after handshake.
  - Beats carry 0140, 0148, 0150, 0158; rlast only on the 4th beat.
- Page miss: then AR addr=16'h0800 (page 1).
  - 8-cycle delay (first beat 9 cycles after handshake).
  - A following AR to 16'h0000 is also a miss (8-cycle delay).
- Backpressure and wrap: AR addr=16'hFFF8, len=1, with rready low for 3 cycles on each beat.
  - rdata, rid and rlast stay stable while stalled.
  - Beats carry FFF8, then 0000 (wrap).
- FIFO full: hold rready=0 and issue 33 back-to-back ARs.
  - arready drops after 32 accepts while the first request's pop is pending.
  - Once the first pop occurs (31 queued), arready reasserts and the 33rd is accepted.
  - All 33 responses are returned in order.
- Reset mid-burst: assert rst during beat 2 of a len=7 burst with 3 requests queued.
  - Next cycle rvalid=0 and arready=1.
  - No further R beats appear; the next AR is treated as a page miss.
